// File: rtl/iq_upconverter.sv
// iq_upconverter: mixes held baseband I/Q onto an NCO carrier, out = I*cos - Q*sin, 4-stage pipeline.
// Define IQ_SYNC_PULSE_EN to add the sync output that pulses on carrier phase wrap.
module iq_upconverter #(
    parameter int LUT_BITS = 8,
    parameter int HOLD     = 16
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [31:0]        phaseInc,
    input  logic               phaseLoad,
    input  logic signed [13:0] I_in,
    input  logic signed [13:0] Q_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [13:0] out,
    output logic               out_valid,
    output logic               underrun
`ifdef IQ_SYNC_PULSE_EN
    ,
    output logic               sync
`endif
);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam logic [LUT_BITS:0] N = {1'b1, {LUT_BITS{1'b0}}};

    // Quarter-wave table evaluated at elaboration: entry k = round(8191*sin(pi/2*k/N))
    function automatic logic [12:0] qsin(int k);
        return 13'($rtoi(8191.0 * $sin(3.141592653589793 * k / (2.0 * (1 << LUT_BITS))) + 0.5));
    endfunction

    logic [12:0] rom [0:(1 << LUT_BITS)];
    for (genvar k = 0; k <= (1 << LUT_BITS); k++) begin : g_rom
        assign rom[k] = qsin(k);
    end

    logic [31:0]          acc_q, inc_q, acc_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic signed [13:0]   i_q, q_q;
    logic                 underrun_q;
    logic [1:0]           quad_q, c_quad;
    logic [LUT_BITS-1:0]  idx_q;
    logic [LUT_BITS:0]    s_ri, c_ri;
    logic signed [13:0]   sin_q, cos_q, sin_d, cos_d;
    logic signed [27:0]   pi_q, pq_q;
    logic signed [15:0]   sh;
    logic signed [13:0]   out_q, out_d;
    logic [1:0]           vcnt_q;
    logic                 valid_q;

    assign in_ready  = hold_q == '0;
    assign hold_d    = in_ready ? HW'(HOLD - 1) : hold_q - 1'b1;
    assign acc_d     = acc_q + inc_q;
    // Cosine shares the sine index; the +2^30 offset only advances the quadrant
    assign c_quad    = quad_q + 2'd1;
    assign s_ri      = quad_q[0] ? N - {1'b0, idx_q} : {1'b0, idx_q};
    assign c_ri      = c_quad[0] ? N - {1'b0, idx_q} : {1'b0, idx_q};
    assign sin_d     = quad_q[1] ? -$signed({1'b0, rom[s_ri]}) : $signed({1'b0, rom[s_ri]});
    assign cos_d     = c_quad[1] ? -$signed({1'b0, rom[c_ri]}) : $signed({1'b0, rom[c_ri]});
    assign sh        = 16'((29'(pi_q) - 29'(pq_q) + 29'sd4096) >>> 13);
    assign out_d     = sh > 16'sd8191 ? 14'sd8191 : (sh < -16'sd8192 ? 14'h2000 : sh[13:0]);
    assign out       = out_q;
    assign out_valid = valid_q;
    assign underrun  = underrun_q;

`ifdef IQ_SYNC_PULSE_EN
    logic [4:0] wrap_q;
    assign sync = wrap_q[4];
    always_ff @(posedge CLK) begin
        if (reset) wrap_q <= '0;
        else       wrap_q <= {wrap_q[3:0], acc_d < acc_q};
    end
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            acc_q      <= '0;
            inc_q      <= '0;
            hold_q     <= '0;
            i_q        <= '0;
            q_q        <= '0;
            underrun_q <= 1'b0;
            quad_q     <= '0;
            idx_q      <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
            pi_q       <= '0;
            pq_q       <= '0;
            out_q      <= '0;
            vcnt_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= phaseLoad ? phaseInc : inc_q;
            hold_q     <= hold_d;
            i_q        <= (in_ready && in_valid) ? I_in : i_q;
            q_q        <= (in_ready && in_valid) ? Q_in : q_q;
            underrun_q <= underrun_q | (in_ready & ~in_valid);
            quad_q     <= acc_q[31:30];
            idx_q      <= acc_q[29:30-LUT_BITS];
            sin_q      <= sin_d;
            cos_q      <= cos_d;
            pi_q       <= 28'(i_q) * 28'(cos_q);
            pq_q       <= 28'(q_q) * 28'(sin_q);
            out_q      <= out_d;
            vcnt_q     <= vcnt_q + 2'(vcnt_q != 2'd3);
            valid_q    <= vcnt_q == 2'd3;
        end
    end
endmodule

// File: tb/tb_iq_upconverter.sv
// tb_iq_upconverter: vector table plus per-cycle scoreboard against a behavioural carrier/mixer model.
module tb_iq_upconverter;
    localparam int HOLD = 4;
    localparam real PI = 3.141592653589793;

    logic               CLK = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        phaseInc = '0;
    logic               phaseLoad = 1'b0;
    logic signed [13:0] I_in = '0, Q_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready, out_valid, underrun;
    logic signed [13:0] out;
`ifdef IQ_SYNC_PULSE_EN
    logic               sync;
`endif

    always #5 CLK = ~CLK;

    iq_upconverter #(.LUT_BITS(8), .HOLD(HOLD)) dut (
        .CLK(CLK), .reset(reset), .phaseInc(phaseInc), .phaseLoad(phaseLoad),
        .I_in(I_in), .Q_in(Q_in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .underrun(underrun)
`ifdef IQ_SYNC_PULSE_EN
        , .sync(sync)
`endif
    );

    int total = 0, bad = 0;

    logic [31:0] m_acc, m_inc;
    int          m_i, m_q, m_hold, m_cnt;
    bit          m_under, car;
    logic [31:0] phq[$];
    int          iqi[$], iqq[$];
    bit          wq[$];

    typedef struct {
        logic [31:0] inc;
        int i, q, e0, e1, e2, e3;
    } vec_t;
    vec_t tv[5];

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Carrier sample from the 10-bit phase: 8191*sin rounded half away from zero
    function automatic int qsin(logic [31:0] ph);
        real v;
        int  m;
        v = 8191.0 * $sin(2.0 * PI * real'(ph[31:22]) / 1024.0);
        m = $rtoi((v < 0.0 ? -v : v) + 0.5);
        return v < 0.0 ? -m : m;
    endfunction

    function automatic longint exp_out(logic [31:0] ph, int i, int q);
        longint s;
        s = longint'(i) * qsin(ph + 32'h4000_0000) - longint'(q) * qsin(ph) + 4096;
        s = s >>> 13;
        return s > 8191 ? 8191 : (s < -8192 ? -8192 : s);
    endfunction

    task automatic model_step();
        bit rdy;
        if (reset) begin
            m_acc = '0; m_inc = '0; m_i = 0; m_q = 0; m_hold = 0; m_cnt = 0; m_under = 0; car = 0;
            phq.delete(); iqi.delete(); iqq.delete(); wq.delete();
        end else begin
            rdy = m_hold == 0;
            if (rdy && in_valid) begin m_i = I_in; m_q = Q_in; end
            if (rdy && !in_valid) m_under = 1;
            m_hold = rdy ? HOLD - 1 : m_hold - 1;
            {car, m_acc} = {1'b0, m_acc} + {1'b0, m_inc};
            if (phaseLoad) m_inc = phaseInc;
            if (m_cnt < 4) m_cnt++;
        end
        phq.push_back(m_acc); wq.push_back(car);
        iqi.push_back(m_i); iqq.push_back(m_q);
        if (phq.size() > 5) begin void'(phq.pop_front()); void'(wq.pop_front()); end
        if (iqi.size() > 3) begin void'(iqi.pop_front()); void'(iqq.pop_front()); end
    endtask

    task automatic check();
        chk("out_valid", out_valid, m_cnt >= 4);
        chk("in_ready", in_ready, m_hold == 0);
        chk("underrun", underrun, m_under);
        if (m_cnt >= 4) chk("out", out, exp_out(phq[0], iqi[0], iqq[0]));
`ifdef IQ_SYNC_PULSE_EN
        chk("sync", sync, phq.size() == 5 ? wq[0] : 0);
`endif
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check();
    endtask

    int rc, sc;

    initial begin
        tv[0] = '{32'd0,         4096,     0,  4096,  4096,  4096,  4096};
        tv[1] = '{32'h4000_0000, 4096,     0,  4096,     0, -4095,     0};
        tv[2] = '{32'h4000_0000,    0,  4096,     0, -4095,     0,  4096};
        tv[3] = '{32'd0,        -8192,  8191, -8191, -8191, -8191, -8191};
        tv[4] = '{32'h2000_0000, 8191, -8192,  8190,  8191,  8191,     1};

        for (int v = 0; v < 5; v++) begin
            reset = 1; phaseLoad = 0; in_valid = 1; phaseInc = tv[v].inc;
            I_in = 14'(tv[v].i); Q_in = 14'(tv[v].q);
            cycle();
            chk("rst_out", out, 0);
            reset = 0; phaseLoad = 1;
            cycle();
            phaseLoad = 0;
            for (int k = 2; k <= 12; k++) begin
                cycle();
                if (k == 5) chk("vec_e0", out, tv[v].e0);
                if (k == 6) chk("vec_e1", out, tv[v].e1);
                if (k == 7) chk("vec_e2", out, tv[v].e2);
                if (k == 8) chk("vec_e3", out, tv[v].e3);
            end
        end

        // Missed ready slot: I_r must hold, underrun sticks, ready once per HOLD cycles
        reset = 1; phaseInc = 0; in_valid = 1; I_in = 1000; Q_in = 0;
        cycle();
        reset = 0; rc = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin in_valid = 0; I_in = 2000; end
            if (k == 9) begin in_valid = 1; I_in = 3000; end
            cycle();
            rc += int'(in_ready);
            if (k == 8) chk("held_out", out, 1000);
            if (k == 12) chk("new_out", out, 3000);
        end
        chk("ready_cnt", rc, 4);
        chk("underrun_sticky", underrun, 1);
        reset = 1;
        cycle();
        chk("underrun_clr", underrun, 0);

        // Carrier wrap and sync alignment, then reset mid-stream
        reset = 0; phaseLoad = 1; phaseInc = 32'h4000_0000; I_in = 4096; Q_in = 0;
        cycle();
        phaseLoad = 0; sc = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
`ifdef IQ_SYNC_PULSE_EN
            if (k >= 4) begin
                sc += int'(sync);
                if (sync) chk("sync_out", out, 4096);
            end
`endif
        end
`ifdef IQ_SYNC_PULSE_EN
        chk("sync_cnt", sc, 4);
`endif
        reset = 1;
        cycle();
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out", out, 0);

        // Random traffic with increment reloads, including loads on wrap edges
        reset = 0;
        for (int k = 0; k < 200; k++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            I_in      = 14'($urandom);
            Q_in      = 14'($urandom);
            phaseLoad = $urandom_range(0, 5) == 0;
            case ($urandom_range(0, 2))
                0:       phaseInc = 32'h8000_0000;
                1:       phaseInc = 32'hC000_0001;
                default: phaseInc = $urandom;
            endcase
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
